wvb_rr_mux: RTL

WVB_RR_MUX -- requirements
Module: wvb_rr_mux

---
 rtl/wvb_rr_mux.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wvb_rr_mux.sv
// wvb_rr_mux: grants one of P_N_CHAN waveform buffer channels to a single
// reader, using round-robin or fixed priority, and holds the grant until the
// reader signals read-done or the channel's header FIFO runs dry.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   en, prio_mode, ch_mask   - arbitration enable, mode (1=fixed), eligibility
//   ch_hdr_empty/ch_hdr_data/ch_wvb_data - per-channel upstream FIFO outputs
//   ch_hdr_rdreq/ch_wvb_rdreq/ch_wvb_rddone - per-channel forwarded requests
//   hdr_empty/hdr_data/wvb_data - muxed view of the granted channel
//   hdr_rdreq/wvb_rdreq/wvb_rddone - reader requests
//   sel_chan, busy, grant_cnt - granted index, grant active, completed count
module wvb_rr_mux #(
    parameter int P_N_CHAN = 4,
    parameter int P_CH_W   = 2,
    parameter int P_HDR_W  = 80,
    parameter int P_DATA_W = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         prio_mode,
    input  logic [P_N_CHAN-1:0]          ch_mask,
    input  logic [P_N_CHAN-1:0]          ch_hdr_empty,
    input  logic [P_N_CHAN*P_HDR_W-1:0]  ch_hdr_data,
    input  logic [P_N_CHAN*P_DATA_W-1:0] ch_wvb_data,
    output logic [P_N_CHAN-1:0]          ch_hdr_rdreq,
    output logic [P_N_CHAN-1:0]          ch_wvb_rdreq,
    output logic [P_N_CHAN-1:0]          ch_wvb_rddone,
    output logic                         hdr_empty,
    output logic [P_HDR_W-1:0]           hdr_data,
    output logic [P_DATA_W-1:0]          wvb_data,
    input  logic                         hdr_rdreq,
    input  logic                         wvb_rdreq,
    input  logic                         wvb_rddone,
    output logic [P_CH_W-1:0]            sel_chan,
    output logic                         busy,
    output logic [15:0]                  grant_cnt
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [P_CH_W-1:0]   sel_q, sel_d;
    logic [P_CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]         cnt_q, cnt_d;
    // Set once the reader has pulled a header; after that an empty header
    // FIFO is normal and must not release the grant.
    logic                hdr_rd_q, hdr_rd_d;

    logic [P_N_CHAN-1:0]   elig;
    logic [2*P_N_CHAN-1:0] dbl;
    logic [P_N_CHAN-1:0]   rot;
    logic [P_CH_W-1:0]     shamt;
    logic [P_CH_W-1:0]     win;
    logic                  win_vld;
    int                    pos;
    int                    sum;

    logic [P_HDR_W-1:0]  hdr_sel;
    logic [P_DATA_W-1:0] wvb_sel;
    logic                sel_empty;
    logic [P_N_CHAN-1:0] sel_oh;
    logic                locked;

    assign elig   = ch_mask & ~ch_hdr_empty;
    assign locked = (state_q == LOCKED);

    // Rotate the eligible vector so the search start sits at bit 0; the
    // first set bit is then the winner's offset from the start index.
    always_comb begin : arb
        shamt   = prio_mode ? '0 : rr_ptr_q;
        dbl     = {elig, elig} >> shamt;
        rot     = dbl[P_N_CHAN-1:0];
        win_vld = |rot;
        pos     = 0;
        for (int i = P_N_CHAN - 1; i >= 0; i--) begin
            if (rot[i]) pos = i;
        end
        sum = int'(shamt) + pos;
        if (sum >= P_N_CHAN) sum = sum - P_N_CHAN;
        win = P_CH_W'(sum);
    end

    always_comb begin : mux
        hdr_sel   = '0;
        wvb_sel   = '0;
        sel_empty = 1'b1;
        sel_oh    = '0;
        for (int k = 0; k < P_N_CHAN; k++) begin
            if (sel_q == P_CH_W'(k)) begin
                hdr_sel   = ch_hdr_data[k*P_HDR_W +: P_HDR_W];
                wvb_sel   = ch_wvb_data[k*P_DATA_W +: P_DATA_W];
                sel_empty = ch_hdr_empty[k];
                sel_oh[k] = 1'b1;
            end
        end
    end

    always_comb begin : nxt
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        hdr_rd_d = hdr_rd_q;
        unique case (state_q)
            IDLE: begin
                if (en && win_vld) begin
                    state_d  = LOCKED;
                    sel_d    = win;
                    hdr_rd_d = 1'b0;
                end
            end
            LOCKED: begin
                if (hdr_rdreq) hdr_rd_d = 1'b1;
                if (wvb_rddone) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 16'd1;
                    if (int'(sel_q) >= P_N_CHAN - 1) rr_ptr_d = '0;
                    else rr_ptr_d = sel_q + 1'b1;
                end else if (!hdr_rd_q && sel_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            hdr_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            hdr_rd_q <= hdr_rd_d;
        end
    end

    assign hdr_empty     = locked ? sel_empty : 1'b1;
    assign hdr_data      = locked ? hdr_sel : '0;
    assign wvb_data      = locked ? wvb_sel : '0;
    assign ch_hdr_rdreq  = (locked && hdr_rdreq) ? sel_oh : '0;
    assign ch_wvb_rdreq  = (locked && wvb_rdreq) ? sel_oh : '0;
    assign ch_wvb_rddone = (locked && wvb_rddone) ? sel_oh : '0;
    assign sel_chan      = sel_q;
    assign busy          = locked;
    assign grant_cnt     = cnt_q;

endmodule
